// File: rtl/link_inject_buffer_pkg.sv
// Shared constants and helpers for the link inject buffer: valid-bit index,
// default skid margin derived from link delay, utilisation counter width.
package link_inject_buffer_pkg;

    localparam int LINK_DELAY_DEF  = 20;
    localparam int SKID_MARGIN_DEF = 2 * LINK_DELAY_DEF;
    localparam int UTIL_W          = 8;

    localparam logic [UTIL_W-1:0] UTIL_ONE = 1;

    function automatic int flit_vld_idx(input int data_width);
        return data_width - 1;
    endfunction

    // Saturating increment used by the utilisation flit counter.
    function automatic logic [UTIL_W-1:0] util_sat_inc(input logic [UTIL_W-1:0] cnt,
                                                       input logic            inc);
        if (inc && (cnt != '1)) begin
            return cnt + UTIL_ONE;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/link_inject_buffer_if.sv
// Link-rx to switch-inject bundle: incoming flits, upstream ready, head flit
// handshake and status outputs. master = environment, slave = buffer.
interface link_inject_buffer_if
    import link_inject_buffer_pkg::*;
#(
    parameter int DataWidth = 256,
    parameter int Depth     = 128
);
    localparam int OccW = $clog2(Depth) + 1;

    logic [DataWidth-1:0] in_flit;
    logic                 in_ready;
    logic [DataWidth-1:0] out_flit;
    logic                 out_valid;
    logic                 out_ready;
    logic [OccW-1:0]      occupancy;
    logic                 overflow;
    logic [UTIL_W-1:0]    inject_util;

    modport master (
        output in_flit, out_ready,
        input  in_ready, out_flit, out_valid, occupancy, overflow, inject_util
    );

    modport slave (
        input  in_flit, out_ready,
        output in_ready, out_flit, out_valid, occupancy, overflow, inject_util
    );

endinterface

// File: rtl/link_inject_fifo.sv
// Synchronous FIFO with natural-wrap pointers, separate occupancy counter.
// Latency: write visible at head (rd_vld) one cycle later.
// Backpressure: none internally; caller must not write when full unless reading.
module link_inject_fifo #(
    parameter int DataWidth = 256,
    parameter int Depth     = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DataWidth-1:0]       wr_dat,
    input  logic                       rd_en,
    output logic [DataWidth-1:0]       rd_dat,
    output logic                       rd_vld,
    output logic [$clog2(Depth):0]     count,
    output logic [$clog2(Depth):0]     count_nxt,
    output logic                       full
);
    localparam int AddrW = $clog2(Depth);
    localparam int OccW  = AddrW + 1;

    logic [AddrW-1:0] wr_ptr;
    logic [AddrW-1:0] rd_ptr;
    logic [OccW-1:0]  count_q;
    logic             vld_q;

    always_comb begin
        count_nxt = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_nxt;
            vld_q   <= (count_nxt != '0);
        end
    end

    generate
        if (Depth <= 4) begin : g_regs
            logic [DataWidth-1:0] mem [0:Depth-1];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < Depth; i++) mem[i] <= '0;
                end else if (wr_en) begin
                    mem[wr_ptr] <= wr_dat;
                end
            end
            assign rd_dat = mem[rd_ptr];
        end else begin : g_ram
            logic [DataWidth-1:0] mem [0:Depth-1];
            always_ff @(posedge clk) begin
                if (wr_en) mem[wr_ptr] <= wr_dat;
            end
            assign rd_dat = mem[rd_ptr];
        end
    endgenerate

    assign rd_vld = vld_q;
    assign count  = count_q;
    assign full   = (count_q == OccW'(Depth));

endmodule

// File: rtl/link_inject_buffer.sv
// Elastic rx buffer from link to switch inject port, with windowed utilisation.
// Latency: 1 cycle enqueue-to-out_valid; 0 with LINK_INJECT_BUFFER_BYPASS_EN.
// Backpressure: in_ready advisory (drops at SkidMargin free); full drops + sticky overflow.
module link_inject_buffer
    import link_inject_buffer_pkg::*;
#(
    parameter int DataWidth      = 256,
    parameter int Depth          = 128,
    parameter int SkidMargin     = SKID_MARGIN_DEF,
    parameter int UtilWindowLog2 = 8
) (
    input logic                 clk,
    input logic                 rst,
    link_inject_buffer_if.slave bus
);
    localparam int VldIdx = flit_vld_idx(DataWidth);
    localparam int OccW   = $clog2(Depth) + 1;

    logic                 in_vld;
    logic                 bypass;
    logic                 wr_en;
    logic                 rd_en;
    logic                 deq;
    logic                 drop;
    logic [DataWidth-1:0] head_dat;
    logic                 head_vld;
    logic [OccW-1:0]      count;
    logic [OccW-1:0]      count_nxt;
    logic                 full;

    logic                      in_ready_q;
    logic                      overflow_q;
    logic [UtilWindowLog2-1:0] win_cnt;
    logic [UTIL_W-1:0]         flit_cnt;
    logic [UTIL_W-1:0]         util_q;

    assign in_vld = bus.in_flit[VldIdx];

`ifdef LINK_INJECT_BUFFER_BYPASS_EN
    assign bypass = !head_vld && in_vld && bus.out_ready;
`else
    assign bypass = 1'b0;
`endif

    // A dequeue at full frees the slot on the same edge, so the arrival is kept.
    assign rd_en = head_vld && bus.out_ready;
    assign wr_en = in_vld && !bypass && (!full || rd_en);
    assign drop  = in_vld && full && !rd_en;

    link_inject_fifo #(
        .DataWidth (DataWidth),
        .Depth     (Depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_dat    (bus.in_flit),
        .rd_en     (rd_en),
        .rd_dat    (head_dat),
        .rd_vld    (head_vld),
        .count     (count),
        .count_nxt (count_nxt),
        .full      (full)
    );

    // Storage is not reset, so the head is masked to keep out_flit zero when idle.
    always_comb begin
        bus.out_flit = '0;
        if (head_vld) begin
            bus.out_flit = head_dat;
        end else if (bypass) begin
            bus.out_flit = bus.in_flit;
        end
    end

    assign bus.out_valid = head_vld || bypass;
    assign deq           = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            in_ready_q <= ((Depth - int'(count_nxt)) > SkidMargin);
            if (drop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_cnt  <= '0;
            flit_cnt <= '0;
            util_q   <= '0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
            if (&win_cnt) begin
                util_q   <= util_sat_inc(flit_cnt, deq);
                flit_cnt <= '0;
            end else begin
                flit_cnt <= util_sat_inc(flit_cnt, deq);
            end
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.occupancy   = count;
    assign bus.overflow    = overflow_q;
    assign bus.inject_util = util_q;

endmodule

// File: tb/tb_link_inject_buffer.sv
module tb_link_inject_buffer;
    localparam int DW    = 256;
    localparam int DEPTH = 128;
    localparam int SKID  = 40;
    localparam int WLOG  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    link_inject_buffer_if #(.DataWidth(DW), .Depth(DEPTH)) bus ();

    link_inject_buffer #(
        .DataWidth      (DW),
        .Depth          (DEPTH),
        .SkidMargin     (SKID),
        .UtilWindowLog2 (WLOG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [DW-1:0] exp_q [$];

    function automatic logic [DW-1:0] mk(input int seq);
        logic [DW-1:0] f;
        f            = '0;
        f[31:0]      = seq;
        f[DW-2 -: 16] = 16'hA5C3 ^ seq[15:0];
        f[DW-1]      = 1'b1;
        return f;
    endfunction

    task automatic reset_pulse();
        bus.in_flit   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        bus.in_flit   = mk(7);
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        vectors++; if (bus.out_flit !== '0) begin miscompares++; $display("FAIL reset_out_flit got %h want 0", bus.out_flit); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        vectors++; if (bus.occupancy !== 8'd0) begin miscompares++; $display("FAIL reset_occupancy got %0d want 0", bus.occupancy); end
        vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
        vectors++; if (bus.inject_util !== 8'd0) begin miscompares++; $display("FAIL reset_inject_util got %0d want 0", bus.inject_util); end
        rst           = 1'b1;
        bus.in_flit   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready got %b want 1", bus.in_ready); end
        vectors++; if (bus.occupancy !== 8'd0) begin miscompares++; $display("FAIL release_occupancy got %0d want 0", bus.occupancy); end
    endtask

    task automatic test_single_flit();
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_flit   = mk(1);
        #1;
`ifdef LINK_INJECT_BUFFER_BYPASS_EN
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL single_bypass_valid got %b want 1", bus.out_valid); end
        vectors++; if (bus.out_flit !== mk(1)) begin miscompares++; $display("FAIL single_bypass_flit got %h want %h", bus.out_flit, mk(1)); end
        @(negedge clk);
        bus.in_flit = '0;
        #1;
        vectors++; if (bus.occupancy !== 8'd0) begin miscompares++; $display("FAIL single_bypass_occ got %0d want 0", bus.occupancy); end
`else
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid got %b want 0", bus.out_valid); end
        @(negedge clk);
        bus.in_flit = '0;
        #1;
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", bus.out_valid); end
        vectors++; if (bus.out_flit !== mk(1)) begin miscompares++; $display("FAIL single_flit got %h want %h", bus.out_flit, mk(1)); end
        vectors++; if (bus.occupancy !== 8'd1) begin miscompares++; $display("FAIL single_occ1 got %0d want 1", bus.occupancy); end
`endif
        @(negedge clk);
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_after_valid got %b want 0", bus.out_valid); end
        vectors++; if (bus.occupancy !== 8'd0) begin miscompares++; $display("FAIL single_after_occ got %0d want 0", bus.occupancy); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_fill_skid();
        bus.out_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (i == 87) begin
                vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready_87 got %b want 1", bus.in_ready); end
                vectors++; if (bus.occupancy !== 8'd87) begin miscompares++; $display("FAIL fill_occ_87 got %0d want 87", bus.occupancy); end
            end
            if (i == 88) begin
                vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready_88 got %b want 0", bus.in_ready); end
                vectors++; if (bus.occupancy !== 8'd88) begin miscompares++; $display("FAIL fill_occ_88 got %0d want 88", bus.occupancy); end
            end
            bus.in_flit = mk(100 + i);
            exp_q.push_back(mk(100 + i));
        end
        @(negedge clk);
        bus.in_flit = '0;
        vectors++; if (bus.occupancy !== 8'd128) begin miscompares++; $display("FAIL fill_occ_full got %0d want 128", bus.occupancy); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready_full got %b want 0", bus.in_ready); end
        vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL fill_overflow got %b want 0", bus.overflow); end
    endtask

    task automatic test_full_simultaneous();
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_flit   = mk(500);
        #1;
        vectors++; if (bus.out_flit !== exp_q[0]) begin miscompares++; $display("FAIL fullsim_head got %h want %h", bus.out_flit, exp_q[0]); end
        void'(exp_q.pop_front());
        exp_q.push_back(mk(500));
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_flit   = '0;
        #1;
        vectors++; if (bus.occupancy !== 8'd128) begin miscompares++; $display("FAIL fullsim_occ got %0d want 128", bus.occupancy); end
        vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL fullsim_overflow got %b want 0", bus.overflow); end
    endtask

    task automatic test_overflow();
        @(negedge clk);
        bus.in_flit = mk(999);
        @(negedge clk);
        bus.in_flit = '0;
        vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set got %b want 1", bus.overflow); end
        vectors++; if (bus.occupancy !== 8'd128) begin miscompares++; $display("FAIL ovf_occ got %0d want 128", bus.occupancy); end
        repeat (3) @(negedge clk);
        vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
    endtask

    task automatic test_drain_order();
        for (int i = 0; i < DEPTH; i++) begin
            bus.out_ready = 1'b1;
            #1;
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_flit !== exp_q[0]) begin
                miscompares++;
                $display("FAIL drain_%0d got v=%b %h want v=1 %h", i, bus.out_valid, bus.out_flit, exp_q[0]);
            end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty_valid got %b want 0", bus.out_valid); end
        vectors++; if (bus.occupancy !== 8'd0) begin miscompares++; $display("FAIL drain_empty_occ got %0d want 0", bus.occupancy); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL drain_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_stream_wrap();
        int sent;
        int got;
        int cyc;
        reset_pulse();
        exp_q.delete();
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 300 && cyc < 4000) begin
            bus.out_ready = (cyc % 2 == 1);
            if (bus.in_ready && sent < 300) begin
                bus.in_flit = mk(1000 + sent);
                exp_q.push_back(mk(1000 + sent));
                sent++;
            end else begin
                bus.in_flit = '0;
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream_extra got %h want nothing", bus.out_flit);
                end else begin
                    if (bus.out_flit !== exp_q[0]) begin
                        miscompares++;
                        $display("FAIL stream_%0d got %h want %h", got, bus.out_flit, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_flit   = '0;
        bus.out_ready = 1'b0;
        vectors++; if (got !== 300) begin miscompares++; $display("FAIL stream_count got %0d want 300", got); end
        vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL stream_left got %0d want 0", exp_q.size()); end
        vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL stream_overflow got %b want 0", bus.overflow); end
        vectors++; if (bus.occupancy !== 8'd0) begin miscompares++; $display("FAIL stream_occ got %0d want 0", bus.occupancy); end
    endtask

    task automatic test_utilisation();
        reset_pulse();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 700; i++) begin
            bus.in_flit = mk(2000 + i);
            @(negedge clk);
        end
        vectors++; if (bus.inject_util !== 8'd255) begin miscompares++; $display("FAIL util_saturated got %0d want 255", bus.inject_util); end
        bus.in_flit = '0;
        repeat (520) @(negedge clk);
        vectors++; if (bus.inject_util !== 8'd0) begin miscompares++; $display("FAIL util_idle got %0d want 0", bus.inject_util); end
        reset_pulse();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.in_flit = mk(i);
            @(negedge clk);
        end
        bus.in_flit = '0;
        repeat (220) @(negedge clk);
        vectors++; if (bus.inject_util !== 8'd100) begin miscompares++; $display("FAIL util_partial got %0d want 100", bus.inject_util); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_stream();
        reset_pulse();
        for (int i = 0; i < 50; i++) begin
            bus.in_flit = mk(3000 + i);
            @(negedge clk);
        end
        bus.in_flit = '0;
        vectors++; if (bus.occupancy !== 8'd50) begin miscompares++; $display("FAIL mid_occ50 got %0d want 50", bus.occupancy); end
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid got %b want 0", bus.out_valid); end
        vectors++; if (bus.out_flit !== '0) begin miscompares++; $display("FAIL mid_rst_flit got %h want 0", bus.out_flit); end
        vectors++; if (bus.occupancy !== 8'd0) begin miscompares++; $display("FAIL mid_rst_occ got %0d want 0", bus.occupancy); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ready got %b want 0", bus.in_ready); end
        vectors++; if (bus.inject_util !== 8'd0) begin miscompares++; $display("FAIL mid_rst_util got %0d want 0", bus.inject_util); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_release_ready got %b want 1", bus.in_ready); end
        for (int i = 0; i < 5; i++) begin
            vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_stale_%0d got %b want 0", i, bus.out_valid); end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_flit   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_flit();
        test_fill_skid();
        test_full_simultaneous();
        test_overflow();
        test_drain_order();
        test_stream_wrap();
        test_utilisation();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
